rvvi_depacketizer: RTL and testbench

RVVI_DEPACKETIZER -- requirements
Module: rvvi_depacketizer

---
 rtl/rvvi_depacketizer.sv | 196 +++++++++++++++++++
 tb/tb_rvvi_depacketizer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_depacketizer.sv
// Receives RVVI trace frames from an Ethernet MAC stream, filters and sequence-checks them,
// holds one decoded record for the host, and returns a short ack frame per consumed record.
module rvvi_depacketizer #(
  parameter int XLEN              = 64,
  parameter int MAX_CSRS          = 5,
  parameter int RVVI_WIDTH        = 128 + 4*XLEN + MAX_CSRS*(XLEN+16),
  parameter int FRAME_COUNT_WIDTH = 64,
  parameter int ETH_HEADER_WIDTH  = 112,
  parameter int PREFIX_PAD        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  RxAxiRdata,
  input  logic [3:0]                   RxAxiRstrb,
  input  logic                         RxAxiRlast,
  input  logic                         RxAxiRvalid,
  output logic [31:0]                  TxAxiWdata,
  output logic [3:0]                   TxAxiWstrb,
  output logic                         TxAxiWlast,
  output logic                         TxAxiWvalid,
  input  logic                         TxAxiWready,
  output logic [RVVI_WIDTH-1:0]        Rvvi,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic                         RvviValid,
  input  logic                         RvviReady,
  input  logic [47:0]                  LocalMac,
  input  logic [47:0]                  RemoteMac,
  input  logic [15:0]                  EthType,
  input  logic [31:0]                  InterPacketDelay,
  output logic [15:0]                  DropCount,
  output logic                         Overflow,
  output logic                         SeqError
);
  localparam int FRAME_BITS = ETH_HEADER_WIDTH + PREFIX_PAD + FRAME_COUNT_WIDTH + RVVI_WIDTH;
  localparam int BEATS      = (FRAME_BITS + 31) / 32;
  localparam int REM        = FRAME_BITS % 32;
  localparam logic [3:0] LAST_STRB = (REM == 0) ? 4'hF : 4'hF >> (4 - (REM + 7) / 8);
  localparam int CW         = $clog2(BEATS + 1);
  localparam int FC_LO      = ETH_HEADER_WIDTH + PREFIX_PAD;
  localparam int RVVI_LO    = FC_LO + FRAME_COUNT_WIDTH;
  localparam int ACK_BITS   = 32 + FRAME_COUNT_WIDTH + 16 + 96;
  localparam int ACK_BEATS  = (ACK_BITS + 31) / 32;
  localparam int ACK_W      = ACK_BEATS * 32;
  localparam int ACK_REM    = ACK_BITS % 32;
  localparam logic [3:0] ACK_LAST_STRB = (ACK_REM == 0) ? 4'hF : 4'hF >> (4 - (ACK_REM + 7) / 8);
  localparam int TBW        = $clog2(ACK_BEATS);

  typedef enum logic {RX_RECV, RX_DROP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t                    r_rx_state;
  tx_state_t                    r_tx_state;
  logic [CW-1:0]                r_cnt;
  logic [(BEATS-1)*32-1:0]      r_beats;
  logic                         r_full;
  logic [RVVI_WIDTH-1:0]        r_rvvi;
  logic [FRAME_COUNT_WIDTH-1:0] r_fc;
  logic [FRAME_COUNT_WIDTH-1:0] r_expected;
  logic                         r_first;
  logic [15:0]                  r_drop_cnt;
  logic                         r_overflow;
  logic                         r_seq_err;
  logic [ACK_W-1:0]             r_ack;
  logic [TBW-1:0]               r_tx_beat;
  logic [31:0]                  r_tx_data;
  logic [3:0]                   r_tx_strb;
  logic                         r_tx_last;
  logic                         r_tx_valid;

  // The final beat is never stored: the frame is judged while it is on the bus.
  logic [BEATS*32-1:0]          w_frame;
  logic                         w_good_len;
  logic                         w_bad_mid;
  logic                         w_match;
  logic                         w_accept;
  logic                         w_drop;
  logic                         w_hs;
  logic [FRAME_COUNT_WIDTH-1:0] w_frame_fc;
  logic [ACK_W-1:0]             w_ack;

  assign w_frame    = {RxAxiRdata, r_beats};
  assign w_frame_fc = w_frame[FC_LO +: FRAME_COUNT_WIDTH];
  assign w_good_len = (r_cnt == CW'(BEATS-1)) && (RxAxiRstrb == LAST_STRB);
  assign w_bad_mid  = (r_cnt >= CW'(BEATS-1)) || (RxAxiRstrb != 4'hF);
  assign w_match    = (w_frame[47:0] == LocalMac) && (w_frame[95:48] == RemoteMac) &&
                      (w_frame[111:96] == EthType);
  assign w_accept   = w_good_len && w_match && !r_full;
  assign w_drop     = RxAxiRvalid && (r_rx_state == RX_RECV) &&
                      (RxAxiRlast ? !w_accept : w_bad_mid);
  assign RvviValid  = r_full && (r_tx_state == TX_IDLE);
  assign w_hs       = RvviValid && RvviReady;
  assign w_ack      = ACK_W'({InterPacketDelay, r_fc, EthType, LocalMac, RemoteMac});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_RECV;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_rvvi     <= '0;
      r_fc       <= '0;
      r_expected <= '0;
      r_first    <= 1'b1;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if (w_hs) r_full <= 1'b0;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (RxAxiRvalid) begin
        case (r_rx_state)
          RX_RECV: begin
            if (RxAxiRlast) begin
              r_cnt <= '0;
              if (w_accept) begin
                r_rvvi     <= w_frame[RVVI_LO +: RVVI_WIDTH];
                r_fc       <= w_frame_fc;
                r_full     <= 1'b1;
                r_first    <= 1'b0;
                r_expected <= w_frame_fc + 1'b1;
                if (!r_first && w_frame_fc != r_expected) r_seq_err <= 1'b1;
              end else if (w_good_len && w_match) begin
                r_overflow <= 1'b1;
              end
            end else if (w_bad_mid) begin
              r_rx_state <= RX_DROP;
            end else begin
              r_beats[32*int'(r_cnt) +: 32] <= RxAxiRdata;
              r_cnt <= r_cnt + 1'b1;
            end
          end
          RX_DROP: begin
            if (RxAxiRlast) begin
              r_rx_state <= RX_RECV;
              r_cnt      <= '0;
            end
          end
          default: r_rx_state <= RX_RECV;
        endcase
      end
    end
  end

  // Ack payload is snapshotted at the handshake so config changes cannot tear an in-flight ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_ack      <= '0;
      r_tx_beat  <= '0;
      r_tx_data  <= '0;
      r_tx_strb  <= '0;
      r_tx_last  <= 1'b0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_hs) begin
            r_ack      <= w_ack;
            r_tx_state <= TX_SEND;
            r_tx_beat  <= '0;
            r_tx_data  <= w_ack[31:0];
            r_tx_strb  <= 4'hF;
            r_tx_last  <= 1'b0;
            r_tx_valid <= 1'b1;
          end
        end
        TX_SEND: begin
          if (TxAxiWready) begin
            if (r_tx_beat == TBW'(ACK_BEATS-1)) begin
              r_tx_state <= TX_IDLE;
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_tx_data  <= '0;
              r_tx_strb  <= '0;
            end else begin
              r_tx_beat <= r_tx_beat + 1'b1;
              r_tx_data <= r_ack[32*(int'(r_tx_beat)+1) +: 32];
              r_tx_strb <= (r_tx_beat == TBW'(ACK_BEATS-2)) ? ACK_LAST_STRB : 4'hF;
              r_tx_last <= (r_tx_beat == TBW'(ACK_BEATS-2));
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign Rvvi        = r_rvvi;
  assign FrameCount  = r_fc;
  assign DropCount   = r_drop_cnt;
  assign Overflow    = r_overflow;
  assign SeqError    = r_seq_err;
  assign TxAxiWdata  = r_tx_data;
  assign TxAxiWstrb  = r_tx_strb;
  assign TxAxiWlast  = r_tx_last;
  assign TxAxiWvalid = r_tx_valid;
endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer: frame filtering, buffering, sequence checking and ack generation.
module tb_rvvi_depacketizer;
  localparam int NB = 31;
  localparam int FW = NB * 32;
  localparam int RW = 784;
  localparam logic [47:0] LMAC  = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] RMAC  = 48'h112233445566;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   RxAxiRdata;
  logic [3:0]    RxAxiRstrb;
  logic          RxAxiRlast, RxAxiRvalid;
  logic [31:0]   TxAxiWdata;
  logic [3:0]    TxAxiWstrb;
  logic          TxAxiWlast, TxAxiWvalid, TxAxiWready;
  logic [RW-1:0] Rvvi;
  logic [63:0]   FrameCount;
  logic          RvviValid, RvviReady;
  logic [47:0]   LocalMac, RemoteMac;
  logic [15:0]   EthType;
  logic [31:0]   InterPacketDelay;
  logic [15:0]   DropCount;
  logic          Overflow, SeqError;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rvvi_depacketizer dut (
    .clk(clk), .reset(reset),
    .RxAxiRdata(RxAxiRdata), .RxAxiRstrb(RxAxiRstrb), .RxAxiRlast(RxAxiRlast), .RxAxiRvalid(RxAxiRvalid),
    .TxAxiWdata(TxAxiWdata), .TxAxiWstrb(TxAxiWstrb), .TxAxiWlast(TxAxiWlast), .TxAxiWvalid(TxAxiWvalid),
    .TxAxiWready(TxAxiWready),
    .Rvvi(Rvvi), .FrameCount(FrameCount), .RvviValid(RvviValid), .RvviReady(RvviReady),
    .LocalMac(LocalMac), .RemoteMac(RemoteMac), .EthType(EthType), .InterPacketDelay(InterPacketDelay),
    .DropCount(DropCount), .Overflow(Overflow), .SeqError(SeqError)
  );

  function automatic logic [RW-1:0] exp_rvvi(input logic [63:0] fc);
    return {49{fc[15:0]}};
  endfunction

  function automatic logic [FW-1:0] mk(input logic [63:0] fc, input logic [47:0] dst);
    logic [FW-1:0] f;
    f = '0;
    f[47:0]    = dst;
    f[95:48]   = RMAC;
    f[111:96]  = ETYPE;
    f[127:112] = 16'hBEEF;
    f[191:128] = fc;
    f[975:192] = exp_rvvi(fc);
    return f;
  endfunction

  // Drives beats 0..last_at back to back; beat bad_at (if any) carries a short strobe.
  task automatic send_frame(input logic [FW-1:0] f, input int last_at, input int bad_at);
    for (int k = 0; k <= last_at; k++) begin
      RxAxiRvalid = 1'b1;
      RxAxiRdata  = f[32*k +: 32];
      RxAxiRlast  = (k == last_at);
      RxAxiRstrb  = (k == last_at && k == NB-1) ? 4'b0011 : 4'hF;
      if (k == bad_at) RxAxiRstrb = 4'h7;
      @(posedge clk); #1;
    end
    RxAxiRvalid = 1'b0;
    RxAxiRlast  = 1'b0;
  endtask

  task automatic collect_ack(input bit toggle, output logic [223:0] ack, output int n);
    logic [31:0] hd;
    logic [3:0]  hs;
    logic        hl;
    bit          held, done;
    n = 0; held = 0; done = 0; ack = '0; hd = '0; hs = '0; hl = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      TxAxiWready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (held && TxAxiWvalid) begin
        total++;
        if ({TxAxiWdata, TxAxiWstrb, TxAxiWlast} !== {hd, hs, hl}) begin
          bad++;
          $display("FAIL stall_hold got=%h/%h/%b want=%h/%h/%b", TxAxiWdata, TxAxiWstrb, TxAxiWlast, hd, hs, hl);
        end
      end
      held = 0;
      if (TxAxiWvalid && TxAxiWready) begin
        if (n < 7) ack[32*n +: 32] = TxAxiWdata;
        n++;
        total++;
        if ({TxAxiWlast, TxAxiWstrb} !== ((n == 7) ? 5'b1_0011 : 5'b0_1111)) begin
          bad++;
          $display("FAIL ack_beat%0d_last_strb got=%b/%b", n-1, TxAxiWlast, TxAxiWstrb);
        end
        if (TxAxiWlast) done = 1;
      end else if (TxAxiWvalid) begin
        held = 1; hd = TxAxiWdata; hs = TxAxiWstrb; hl = TxAxiWlast;
      end
      @(posedge clk); #1;
    end
    TxAxiWready = 1'b1;
    if (!done) begin
      bad++;
      $display("FAIL ack_timeout got=%0d beats want=7", n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({RvviValid, TxAxiWvalid, TxAxiWlast, TxAxiWstrb, TxAxiWdata} !== '0) begin
      bad++; $display("FAIL reset_ctl got=%b%b%b %h %h", RvviValid, TxAxiWvalid, TxAxiWlast, TxAxiWstrb, TxAxiWdata);
    end
    total++;
    if ({DropCount, Overflow, SeqError} !== '0) begin
      bad++; $display("FAIL reset_status got=%h %b %b", DropCount, Overflow, SeqError);
    end
    total++;
    if (Rvvi !== '0 || FrameCount !== 64'd0) begin
      bad++; $display("FAIL reset_data got fc=%h", FrameCount);
    end
  endtask

  task automatic test_good;
    logic [223:0] ack;
    int n;
    RvviReady = 1'b1;
    send_frame(mk(64'd5, LMAC), NB-1, -1);
    total++;
    if (RvviValid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b want=1", RvviValid); end
    total++;
    if (FrameCount !== 64'd5) begin bad++; $display("FAIL good_fc got=%h want=5", FrameCount); end
    total++;
    if (Rvvi !== exp_rvvi(64'd5)) begin bad++; $display("FAIL good_rvvi got=%h", Rvvi[63:0]); end
    collect_ack(1'b0, ack, n);
    total++;
    if (n != 7) begin bad++; $display("FAIL good_ack_beats got=%0d want=7", n); end
    total++;
    if (ack[207:0] !== {32'hA1B2C3D4, 64'd5, ETYPE, LMAC, RMAC}) begin
      bad++; $display("FAIL good_ack_data got=%h", ack[207:0]);
    end
    total++;
    if (ack[127:96] !== {16'h0005, ETYPE}) begin bad++; $display("FAIL good_ack_beat3 got=%h", ack[127:96]); end
    total++;
    if (ack[207:192] !== 16'hA1B2) begin bad++; $display("FAIL good_ack_beat6 got=%h want=a1b2", ack[207:192]); end
    total++;
    if ({DropCount, SeqError, Overflow} !== '0) begin bad++; $display("FAIL good_status got=%h %b %b", DropCount, SeqError, Overflow); end
  endtask

  task automatic test_short;
    logic [223:0] ack;
    int n;
    send_frame(mk(64'd6, LMAC), 29, -1);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (RvviValid !== 1'b0 || DropCount !== 16'd1) begin
      bad++; $display("FAIL short_drop got valid=%b drops=%0d want 0/1", RvviValid, DropCount);
    end
    send_frame(mk(64'd6, LMAC), NB-1, -1);
    total++;
    if (RvviValid !== 1'b1 || FrameCount !== 64'd6) begin
      bad++; $display("FAIL short_recover got valid=%b fc=%h", RvviValid, FrameCount);
    end
    collect_ack(1'b0, ack, n);
    total++;
    if (n != 7 || ack[175:112] !== 64'd6) begin bad++; $display("FAIL short_ack got n=%0d fc=%h", n, ack[175:112]); end
  endtask

  task automatic test_mac_drop;
    int seen;
    seen = 0;
    send_frame(mk(64'd7, LMAC ^ 48'd1), NB-1, -1);
    for (int c = 0; c < 8; c++) begin
      if (TxAxiWvalid || RvviValid) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0 || DropCount !== 16'd2) begin
      bad++; $display("FAIL mac_drop got seen=%0d drops=%0d want 0/2", seen, DropCount);
    end
    send_frame(mk(64'd7, LMAC), NB-1, 3);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (RvviValid !== 1'b0 || DropCount !== 16'd3) begin
      bad++; $display("FAIL strb_drop got valid=%b drops=%0d want 0/3", RvviValid, DropCount);
    end
  endtask

  task automatic test_overflow;
    logic [223:0] ack;
    int n, seen;
    test_reset();
    RvviReady = 1'b0;
    send_frame(mk(64'd7, LMAC), NB-1, -1);
    send_frame(mk(64'd8, LMAC), NB-1, -1);
    total++;
    if (RvviValid !== 1'b1 || FrameCount !== 64'd7) begin
      bad++; $display("FAIL ovf_hold got valid=%b fc=%h want 1/7", RvviValid, FrameCount);
    end
    total++;
    if (Overflow !== 1'b1 || DropCount !== 16'd1) begin
      bad++; $display("FAIL ovf_flag got ovf=%b drops=%0d want 1/1", Overflow, DropCount);
    end
    RvviReady = 1'b1;
    collect_ack(1'b0, ack, n);
    total++;
    if (n != 7 || ack[175:112] !== 64'd7) begin bad++; $display("FAIL ovf_ack got n=%0d fc=%h", n, ack[175:112]); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (TxAxiWvalid || RvviValid) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0 || Overflow !== 1'b1) begin bad++; $display("FAIL ovf_single got seen=%0d ovf=%b", seen, Overflow); end
  endtask

  task automatic test_seq;
    logic [223:0] ack;
    int n;
    test_reset();
    RvviReady = 1'b1;
    send_frame(mk(64'd7, LMAC), NB-1, -1);
    collect_ack(1'b0, ack, n);
    send_frame(mk(64'd8, LMAC), NB-1, -1);
    collect_ack(1'b0, ack, n);
    total++;
    if (SeqError !== 1'b0) begin bad++; $display("FAIL seq_after8 got=%b want=0", SeqError); end
    send_frame(mk(64'd10, LMAC), NB-1, -1);
    @(posedge clk); #1;
    InterPacketDelay = 32'h55667788;
    collect_ack(1'b1, ack, n);
    total++;
    if (SeqError !== 1'b1) begin bad++; $display("FAIL seq_after10 got=%b want=1", SeqError); end
    total++;
    if (n != 7) begin bad++; $display("FAIL seq_stall_beats got=%0d want=7", n); end
    total++;
    if (ack[207:0] !== {32'hA1B2C3D4, 64'd10, ETYPE, LMAC, RMAC}) begin
      bad++; $display("FAIL seq_ack_capture got=%h", ack[207:0]);
    end
    InterPacketDelay = 32'hA1B2C3D4;
    send_frame(mk(64'd11, LMAC), NB-1, -1);
    collect_ack(1'b0, ack, n);
    total++;
    if (SeqError !== 1'b1) begin bad++; $display("FAIL seq_sticky got=%b want=1", SeqError); end
  endtask

  task automatic test_reset_mid;
    logic [FW-1:0] f;
    logic [223:0]  ack;
    int n, seen;
    f = mk(64'd20, LMAC);
    for (int k = 0; k <= 15; k++) begin
      RxAxiRvalid = 1'b1; RxAxiRlast = 1'b0; RxAxiRstrb = 4'hF;
      RxAxiRdata  = f[32*k +: 32];
      if (k == 15) reset = 1'b1;
      @(posedge clk); #1;
    end
    RxAxiRvalid = 1'b0;
    reset = 1'b0;
    total++;
    if ({RvviValid, TxAxiWvalid, DropCount, Overflow, SeqError, FrameCount} !== '0) begin
      bad++; $display("FAIL rstmid_frame got v=%b drops=%0d seq=%b", RvviValid, DropCount, SeqError);
    end
    send_frame(f, NB-1, -1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({RvviValid, TxAxiWvalid, TxAxiWlast, TxAxiWstrb, TxAxiWdata} !== '0 || Rvvi !== '0 || FrameCount !== 64'd0) begin
      bad++; $display("FAIL rstmid_ack got v=%b tv=%b data=%h fc=%h", RvviValid, TxAxiWvalid, TxAxiWdata, FrameCount);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (TxAxiWvalid || RvviValid) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d want=0", seen); end
    send_frame(mk(64'd21, LMAC), NB-1, -1);
    total++;
    if (RvviValid !== 1'b1 || FrameCount !== 64'd21 || Rvvi !== exp_rvvi(64'd21)) begin
      bad++; $display("FAIL rstmid_next got v=%b fc=%h", RvviValid, FrameCount);
    end
    collect_ack(1'b0, ack, n);
    total++;
    if (n != 7 || ack[175:112] !== 64'd21 || SeqError !== 1'b0) begin
      bad++; $display("FAIL rstmid_next_ack got n=%0d fc=%h seq=%b", n, ack[175:112], SeqError);
    end
  endtask

  initial begin
    reset = 1'b1;
    RxAxiRdata = '0; RxAxiRstrb = '0; RxAxiRlast = 1'b0; RxAxiRvalid = 1'b0;
    TxAxiWready = 1'b1; RvviReady = 1'b0;
    LocalMac = LMAC; RemoteMac = RMAC; EthType = ETYPE; InterPacketDelay = 32'hA1B2C3D4;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_good();
    test_short();
    test_mac_drop();
    test_overflow();
    test_seq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
